// File: rtl/axis_pkg.sv
// Shared AXI-Stream arbitration types and the round-robin pick helper.
package axis_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  localparam int MAX_SRC       = 8;
  localparam int DEF_MAX_BEATS = 16;
  localparam int BEAT_CNT_W    = $clog2(DEF_MAX_BEATS + 1);

  // One-hot winner: first set bit of req searching upward from (last+1) mod n.
  function automatic logic [MAX_SRC-1:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                                 input int unsigned last,
                                                 input int unsigned n);
    logic [MAX_SRC-1:0] win;
    logic               found;
    int unsigned        idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned o = 1; o <= MAX_SRC; o++) begin
      if (n != 0 && o <= n && !found) begin
        idx = (last + o) % n;
        if (req[idx[2:0]]) begin
          win[idx[2:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: one-hot winner and its index.
module rr_priority_pick
  import axis_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_SRC-1:0] win_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [MAX_SRC-1:0] req_ext;
  logic [MAX_SRC-1:0] win_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_SRC-1:0]   = req_i;
    win_ext                = rr_pick(req_ext, 32'(last_i), NUM_SRC);
    win_o                  = win_ext[NUM_SRC-1:0];
    idx_o                  = '0;
    for (int i = 0; i < MAX_SRC; i++)
      if (win_ext[i]) idx_o = IDX_W'(i);
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter; grant held until the accepted
// last beat, with a beat limit that forces tlast on runaway packets.
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter  int NUM_SRC   = 4,
  parameter  int DATA_W    = 16,
  parameter  int MAX_BEATS = 16,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1),
  localparam int IDX_W     = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic [NUM_SRC-1:0]        s_tready,
  output logic                      m_tvalid,
  output logic [DATA_W-1:0]         m_tdata,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [NUM_SRC-1:0]        grant,
  output logic [CNT_W-1:0]          beat_cnt,
  output logic                      err_overlong
);

  arb_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [NUM_SRC-1:0] pick_win;
  logic [IDX_W-1:0]   pick_idx;
  logic               own_vld, own_last, at_limit, accept;
  logic [DATA_W-1:0]  own_data;

  rr_priority_pick #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_pick (
    .req_i  (s_tvalid),
    .last_i (last_q),
    .win_o  (pick_win),
    .idx_o  (pick_idx)
  );

  // Output mux is driven straight from the registered grant; grant is 0 in IDLE.
  always_comb begin
    own_data = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (grant_q[i]) own_data = own_data | s_tdata[i*DATA_W +: DATA_W];
  end

  assign own_vld  = |(s_tvalid & grant_q);
  assign own_last = |(s_tlast & grant_q);
  assign at_limit = (cnt_q == CNT_W'(MAX_BEATS - 1));

  assign m_tvalid = (state_q == BUSY) & own_vld;
  assign m_tdata  = own_data;
  assign m_tlast  = (state_q == BUSY) & (own_last | at_limit);
  assign s_tready = grant_q & {NUM_SRC{m_tready}};
  assign accept   = m_tvalid & m_tready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|s_tvalid) begin
          grant_d = pick_win;
          last_d  = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          if (m_tlast) begin
            err_d   = at_limit & ~own_last;
            cnt_d   = '0;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_SRC - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign grant        = grant_q;
  assign beat_cnt     = cnt_q;
  assign err_overlong = err_q;

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream sink (e.g. `axi_stream_slave`) among up to NUM_SRC AXI-Stream sources (e.g. instances of `axi_stream_master`). The grant is held for a whole packet, from first beat to the accepted `tlast` beat, so packets are never interleaved. A configurable beat limit keeps a source that never asserts `tlast` from locking the sink.

## Interface
- NUM_SRC, 4, number of source ports (2..8)
- DATA_W, 16, tdata width
- MAX_BEATS, 16, maximum beats per granted packet (≥1)
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  reset, asynchronous, active-low
- s_tvalid  in  NUM_SRC  per-source valid
- s_tdata  in  NUM_SRC*DATA_W  flattened data; source i at [i*DATA_W +: DATA_W]
- s_tlast  in  NUM_SRC  per-source last
- s_tready  out  NUM_SRC  per-source ready
- m_tvalid  out  1  sink valid
- m_tdata  out  DATA_W  sink data
- m_tlast  out  1  sink last (source tlast, or forced)
- m_tready  in  1  sink ready
- grant  out  NUM_SRC  one-hot current owner, 0 when idle
- beat_cnt  out  $clog2(MAX_BEATS+1)  beats accepted in current packet
- err_overlong  out  1  one-cycle pulse when a packet is truncated at MAX_BEATS

## Operation
- FSM states: IDLE, BUSY.
- IDLE: grant=0; all s_tready=0; m_tvalid=0. If any s_tvalid=1, choose the first requesting index searching upward from (last+1) mod NUM_SRC. Register grant, set last=winner, go to BUSY.
- BUSY, owner k: m_tvalid=s_tvalid[k], m_tdata=s_tdata[k], m_tlast=s_tlast[k] | (beat_cnt==MAX_BEATS-1), s_tready[k]=m_tready, all other s_tready=0. The mux is combinational from the registered grant.
- Beat accepted when m_tvalid & m_tready. On acceptance, beat_cnt increments. If m_tlast=1, beat_cnt goes to 0 and the FSM goes to IDLE.
- Forced last (beat_cnt==MAX_BEATS-1 and s_tlast[k]=0): the beat goes out with m_tlast=1, err_overlong pulses on the following cycle, and the FSM releases to IDLE. The source's remaining beats compete later as a new packet.
- Owner may drop s_tvalid mid-packet. The grant is held and nothing is forwarded until the owner resumes.
- Requests from non-owners are ignored until the FSM returns to IDLE. A request that drops before being granted is lost; no state is kept for it.
- Reset values: state=IDLE, grant=0, last=NUM_SRC-1 (source 0 wins first), beat_cnt=0, err_overlong=0. Hence s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0.
- Reset mid-packet aborts immediately and asynchronously: outputs take reset values, and the partial packet is not completed on the sink.

## Timing
- Arbitration latency is 1 cycle: request seen in IDLE, and the granted data is visible on m_* the next cycle.
- There is exactly one IDLE cycle between consecutive packets, including back-to-back packets from the same source.
- Data path is zero latency in BUSY; s_tready tracks m_tready combinationally.
- Throughput is 1 beat/cycle within a packet while source valid and sink ready are both high.
- err_overlong is registered: high for the cycle after the forced-last beat.
- With all sources requesting continuously, service order is 0,1,2,3,0,…, and no source waits more than NUM_SRC-1 packets.

## Structure
- Shared package `axis_pkg`:
  - FSM state enum {IDLE, BUSY}.
  - Localparam for the beat counter width.
  - Function `rr_pick(req, last)` returning a one-hot winner.
- One natural sub-module: `rr_priority_pick`, combinational round-robin selector (inputs req[NUM_SRC] and last index; outputs one-hot winner and its index). It is reusable by later arbiters in the codebase.
- Top holds the FSM, grant/last registers, beat counter, and output mux.

## Test plan
- Single source: s_tvalid[2]=1, packet 800..808 with tlast on 808, m_tready=1.
  - Cycle after the request: grant=4'b0100.
  - m_tdata emits 800..808 on consecutive cycles, with m_tlast only on 808.
  - IDLE for one cycle, then re-grant.
- All four sources requesting, 2-beat packets each:
  - grant sequence 0001, 0010, 0100, 1000, 0001.
  - No interleaving within any packet on m_*.
- Backpressure: m_tready toggles every cycle during a packet from source 1.
  - s_tready[1] mirrors m_tready.
  - Each beat appears exactly once; beat_cnt is correct.
  - Other s_tready stay 0.
- Overlong: MAX_BEATS=16, source 0 sends 20 beats with no tlast.
  - Beat 16 exits with m_tlast=1, and err_overlong pulses the next cycle.
  - Beats 17–20 go out as a new packet after arbitration.
- Reset mid-packet: assert resetn=0 at beat 3 of 9.
  - m_tvalid, s_tready, and grant go to 0 without waiting for a clock edge.
  - After release, the first grant goes to source 0 when all sources request.
- Owner stall: the source drops s_tvalid for 5 cycles mid-packet while another source requests.
  - The grant does not change, and m_tvalid=0 during the stall.
  - The packet completes, then the other source is granted.
